// File: rtl/seg7_scan_reader.sv
// Recovers a 4-digit hex value from a multiplexed active-low 7-segment scan (seg/an) and hands
// it out over a valid/ready handshake. Define SEG7_SCAN_READER_ERRCNT_EN to add the err_cnt output.
module seg7_scan_reader #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned TIMEOUT       = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] value,
    output logic [3:0]  digit_err,
    output logic        valid,
`ifdef SEG7_SCAN_READER_ERRCNT_EN
    output logic [7:0]  err_cnt,
`endif
    input  logic        ready
);

    localparam logic [7:0]  StableMax  = 8'(STABLE_CYCLES);
    localparam logic [16:0] TimeoutVal = 17'(TIMEOUT);

    typedef enum logic {StCollect, StPresent} state_e;

    state_e      state_q, state_d;
    logic [6:0]  prev_seg_q, prev_seg_d;
    logic [3:0]  prev_an_q, prev_an_d;
    logic [7:0]  stab_q, stab_d;
    logic [15:0] tmo_q, tmo_d;
    logic [3:0]  mask_q, mask_d;
    logic [15:0] nib_q, nib_d;
    logic [3:0]  nerr_q, nerr_d;
    logic [15:0] value_q, value_d;
    logic [3:0]  digit_err_q, digit_err_d;
    logic        valid_q, valid_d;

    logic        an_legal;
    logic [1:0]  an_idx;
    logic [3:0]  dec_nib;
    logic        dec_err;
    logic        restart;
    logic        stab_hit;
    logic [16:0] tmo_inc;
    logic        tmo_hit;
    logic        capture;

    // Exactly one enable low selects a digit; anything else is treated as bus noise.
    always_comb begin
        an_legal = 1'b1;
        an_idx   = 2'd0;
        unique case (an)
            4'b1110: an_idx = 2'd0;
            4'b1101: an_idx = 2'd1;
            4'b1011: an_idx = 2'd2;
            4'b0111: an_idx = 2'd3;
            default: an_legal = 1'b0;
        endcase
    end

    always_comb begin
        dec_nib = 4'h0;
        dec_err = 1'b0;
        case (seg)
            7'b0000001: dec_nib = 4'h0;
            7'b1001111: dec_nib = 4'h1;
            7'b0010010: dec_nib = 4'h2;
            7'b0000110: dec_nib = 4'h3;
            7'b1001100: dec_nib = 4'h4;
            7'b0100100: dec_nib = 4'h5;
            7'b0100000: dec_nib = 4'h6;
            7'b0001111: dec_nib = 4'h7;
            7'b0000000: dec_nib = 4'h8;
            7'b0000100: dec_nib = 4'h9;
            7'b0001000: dec_nib = 4'hA;
            7'b1100000: dec_nib = 4'hB;
            7'b0110001: dec_nib = 4'hC;
            7'b1000010: dec_nib = 4'hD;
            7'b0110000: dec_nib = 4'hE;
            7'b0111000: dec_nib = 4'hF;
            default:    dec_err = 1'b1;
        endcase
    end

    // Stability tracking runs in every state so a pattern held across PRESENT is not re-captured.
    always_comb begin
        prev_seg_d = seg;
        prev_an_d  = an;
        restart    = !an_legal || (an != prev_an_q) || (seg != prev_seg_q);
        if (restart) begin
            stab_d = 8'd1;
        end else if (stab_q >= StableMax) begin
            stab_d = StableMax;
        end else begin
            stab_d = stab_q + 8'd1;
        end
        stab_hit = (stab_d == StableMax) && (restart || (stab_q != StableMax));
    end

    always_comb begin
        tmo_inc = {1'b0, tmo_q} + 17'd1;
        tmo_hit = (state_q == StCollect) && (mask_q != 4'b0000) && (tmo_inc >= TimeoutVal);
        capture = (state_q == StCollect) && an_legal && stab_hit && !mask_q[an_idx] && !tmo_hit;
    end

    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        mask_d      = mask_q;
        nib_d       = nib_q;
        nerr_d      = nerr_q;
        value_d     = value_q;
        digit_err_d = digit_err_q;
        valid_d     = valid_q;

        unique case (state_q)
            StCollect: begin
                if (mask_q == 4'b0000) begin
                    tmo_d = 16'h0000;
                end else if (tmo_hit) begin
                    tmo_d  = 16'h0000;
                    mask_d = 4'b0000;
                end else begin
                    tmo_d = tmo_inc[15:0];
                end

                if (capture) begin
                    mask_d[an_idx]               = 1'b1;
                    nib_d[{an_idx, 2'b00} +: 4] = dec_nib;
                    nerr_d[an_idx]               = dec_err;
                    if (mask_d == 4'b1111) begin
                        state_d     = StPresent;
                        value_d     = nib_d;
                        digit_err_d = nerr_d;
                        valid_d     = 1'b1;
                    end
                end
            end
            StPresent: begin
                if (valid_q && ready) begin
                    state_d = StCollect;
                    valid_d = 1'b0;
                    mask_d  = 4'b0000;
                    tmo_d   = 16'h0000;
                end
            end
            default: state_d = StCollect;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StCollect;
            prev_seg_q  <= 7'h7F;
            prev_an_q   <= 4'hF;
            stab_q      <= 8'd0;
            tmo_q       <= 16'h0000;
            mask_q      <= 4'b0000;
            nib_q       <= 16'h0000;
            nerr_q      <= 4'b0000;
            value_q     <= 16'h0000;
            digit_err_q <= 4'b0000;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_seg_q  <= prev_seg_d;
            prev_an_q   <= prev_an_d;
            stab_q      <= stab_d;
            tmo_q       <= tmo_d;
            mask_q      <= mask_d;
            nib_q       <= nib_d;
            nerr_q      <= nerr_d;
            value_q     <= value_d;
            digit_err_q <= digit_err_d;
            valid_q     <= valid_d;
        end
    end

    assign value     = value_q;
    assign digit_err = digit_err_q;
    assign valid     = valid_q;

`ifdef SEG7_SCAN_READER_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // Counts presented frames carrying any bad digit; sticks at 255.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if ((state_q == StCollect) && (state_d == StPresent) && (digit_err_d != 4'b0000) &&
            (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    // Error counter not built.
`endif

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed bench for seg7_scan_reader; define SEG7_SCAN_READER_ERRCNT_EN to also exercise err_cnt.
module tb_seg7_scan_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] value;
    logic [3:0]  digit_err;
    logic        valid;
    logic        ready;
`ifdef SEG7_SCAN_READER_ERRCNT_EN
    logic [7:0]  err_cnt;
`endif

    int errors = 0;
    int checks = 0;

    localparam logic [6:0] Bad = 7'b1111110;

    seg7_scan_reader #(
        .STABLE_CYCLES(4),
        .TIMEOUT      (100)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .seg      (seg),
        .an       (an),
        .value    (value),
        .digit_err(digit_err),
        .valid    (valid),
`ifdef SEG7_SCAN_READER_ERRCNT_EN
        .err_cnt  (err_cnt),
`endif
        .ready    (ready)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] enc(input logic [3:0] n);
        case (n)
            4'h0: enc = 7'b0000001;
            4'h1: enc = 7'b1001111;
            4'h2: enc = 7'b0010010;
            4'h3: enc = 7'b0000110;
            4'h4: enc = 7'b1001100;
            4'h5: enc = 7'b0100100;
            4'h6: enc = 7'b0100000;
            4'h7: enc = 7'b0001111;
            4'h8: enc = 7'b0000000;
            4'h9: enc = 7'b0000100;
            4'hA: enc = 7'b0001000;
            4'hB: enc = 7'b1100000;
            4'hC: enc = 7'b0110001;
            4'hD: enc = 7'b1000010;
            4'hE: enc = 7'b0110000;
            default: enc = 7'b0111000;
        endcase
    endfunction

    function automatic logic [3:0] sel(input int d);
        logic [3:0] one;
        one = 4'b0001;
        sel = ~(one << d);
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one digit for n rising edges; returns 1 time unit after the last edge.
    task automatic show(input int d, input logic [6:0] s, input int n);
        an  = sel(d);
        seg = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic blank(input int n);
        an  = 4'b1111;
        seg = 7'h7F;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        ready = 1'b0;
        an    = 4'b1111;
        seg   = 7'h7F;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_valid", valid, 1'b0);
        chk("reset_value", value, 16'h0000);
        chk("reset_derr", digit_err, 4'b0000);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // In-order scan, 1-cycle presentation with ready high
        ready = 1'b1;
        show(0, enc(4'h1), 6);
        show(1, enc(4'h2), 6);
        show(2, enc(4'h3), 6);
        chk("inorder_not_yet", valid, 1'b0);
        show(3, enc(4'h4), 4);
        chk("inorder_valid", valid, 1'b1);
        chk("inorder_value", value, 16'h4321);
        chk("inorder_derr", digit_err, 4'b0000);
        show(3, enc(4'h4), 1);
        chk("inorder_valid_drop", valid, 1'b0);
        show(3, enc(4'h4), 1);
        chk("inorder_valid_stays", valid, 1'b0);

        // Glitch rejection on digit 2, out-of-order capture
        show(2, enc(4'h8), 3);
        show(2, enc(4'hA), 4);
        show(0, enc(4'h0), 5);
        show(3, enc(4'hF), 5);
        show(1, enc(4'h1), 4);
        chk("glitch_valid", valid, 1'b1);
        chk("glitch_value", value, 16'hFA10);
        show(1, enc(4'h1), 1);
        chk("glitch_valid_drop", valid, 1'b0);

        // Invalid pattern on digit 1, output held while ready low
        ready = 1'b0;
        show(0, enc(4'h5), 5);
        show(1, Bad, 5);
        show(2, enc(4'hE), 5);
        show(3, enc(4'hC), 4);
        chk("bad_valid", valid, 1'b1);
        chk("bad_value", value, 16'hCE05);
        chk("bad_derr", digit_err, 4'b0010);
        an  = sel(0);
        seg = enc(4'h8);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", valid, 1'b1);
            chk("hold_value", value, 16'hCE05);
        end
        chk("hold_derr", digit_err, 4'b0010);
        ready = 1'b1;
        @(posedge clk);
        #1;
        chk("hold_release", valid, 1'b0);
        chk("hold_value_after", value, 16'hCE05);

        // Partial frame times out; the stranded digits must not complete a later frame
        show(0, enc(4'h7), 4);
        show(1, enc(4'h9), 4);
        blank(100);
        chk("tmo_blank_valid", valid, 1'b0);
        show(2, enc(4'h2), 4);
        show(3, enc(4'h3), 4);
        chk("tmo_no_valid", valid, 1'b0);
        show(0, enc(4'hA), 4);
        show(1, enc(4'hB), 4);
        chk("tmo_new_valid", valid, 1'b1);
        chk("tmo_new_value", value, 16'h32BA);
        show(1, enc(4'hB), 1);

        // Last capture one cycle before the timeout edge still completes
        show(0, enc(4'h6), 4);
        show(1, enc(4'h7), 4);
        show(2, enc(4'h8), 4);
        blank(87);
        show(3, enc(4'h9), 4);
        chk("tmo_edge_minus1_valid", valid, 1'b1);
        chk("tmo_edge_minus1_value", value, 16'h9876);
        show(3, enc(4'h9), 1);

        // Last capture on the timeout edge is dropped
        show(0, enc(4'hD), 4);
        show(1, enc(4'hE), 4);
        show(2, enc(4'hF), 4);
        blank(88);
        show(3, enc(4'h0), 4);
        chk("tmo_edge_drop", valid, 1'b0);
        show(3, enc(4'h0), 2);
        chk("tmo_edge_no_recapture", valid, 1'b0);
        show(0, enc(4'h1), 4);
        show(1, enc(4'h2), 4);
        show(2, enc(4'h3), 4);
        chk("tmo_edge_partial", valid, 1'b0);
        show(3, enc(4'h4), 4);
        chk("tmo_edge_refill_valid", valid, 1'b1);
        chk("tmo_edge_refill_value", value, 16'h4321);
        show(3, enc(4'h4), 1);

        // Illegal enables capture nothing; reset mid-frame discards the partial mask
        an  = 4'b0011;
        seg = enc(4'h5);
        repeat (10) @(posedge clk);
        #1;
        show(0, enc(4'h1), 4);
        show(1, enc(4'h2), 4);
        show(2, enc(4'h3), 4);
        chk("illegal_an_no_capture", valid, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", valid, 1'b0);
        chk("midrst_value", value, 16'h0000);
        chk("midrst_derr", digit_err, 4'b0000);
        @(posedge clk);
        #1 rst_n = 1'b1;
        show(3, enc(4'h6), 4);
        chk("midrst_mask_cleared", valid, 1'b0);
        show(0, enc(4'h7), 4);
        show(1, enc(4'h8), 4);
        show(2, enc(4'h9), 4);
        chk("postrst_valid", valid, 1'b1);
        chk("postrst_value", value, 16'h6987);
        show(2, enc(4'h9), 1);

        // Reset while presenting drops valid at once
        ready = 1'b0;
        show(0, enc(4'h2), 4);
        show(1, enc(4'h4), 4);
        show(2, enc(4'h6), 4);
        show(3, enc(4'h8), 4);
        chk("present_valid", valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("present_rst_valid", valid, 1'b0);
        chk("present_rst_value", value, 16'h0000);
        @(posedge clk);
        #1 rst_n = 1'b1;
        ready = 1'b1;

`ifdef SEG7_SCAN_READER_ERRCNT_EN
        chk("errcnt_reset", err_cnt, 8'd0);
        for (int f = 0; f < 300; f++) begin
            show(0, Bad, 4);
            show(1, enc(4'h1), 4);
            show(2, enc(4'h2), 4);
            show(3, enc(4'h3), 4);
            if (f == 0) begin
                chk("errcnt_first", err_cnt, 8'd1);
                chk("errcnt_first_derr", digit_err, 4'b0001);
                chk("errcnt_first_value", value, 16'h3210);
            end
            if (f == 253) chk("errcnt_254", err_cnt, 8'd254);
            if (f == 254) chk("errcnt_255", err_cnt, 8'd255);
        end
        show(3, enc(4'h3), 1);
        chk("errcnt_saturated", err_cnt, 8'd255);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_reader.md
SEG7_SCAN_READER -- requirements
Module: seg7_scan_reader

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4 (range 1..255): consecutive cycles a digit pattern must hold before capture.
REQ-002 SHALL have parameter TIMEOUT, default 65535 (16-bit): maximum cycles allowed in COLLECT before a partial frame is discarded.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port seg, input, 7 bits: segment bus {a,b,c,d,e,f,g}, active-low (0 = lit).
REQ-006 SHALL have port an, input, 4 bits: digit enables, active-low, where an[i]=0 selects digit i.
REQ-007 SHALL have port value, output, 16 bits: decoded frame, with digit i in value[4i+3:4i].
REQ-008 SHALL have port digit_err, output, 4 bits: per-digit flag for an unrecognised pattern.
REQ-009 SHALL have port valid, output, 1 bit: frame available.
REQ-010 SHALL have port ready, input, 1 bit: consumer accepts the frame.

Function
REQ-011 SHALL use states COLLECT and PRESENT only.
REQ-012 SHALL treat an as legal only when exactly one bit is 0; all-high or multi-low is illegal.
REQ-013 SHALL keep a stability counter that resets to 1 when an is illegal or when an or seg changes from the previous cycle, and otherwise increments, saturating at STABLE_CYCLES.
REQ-014 SHALL, in COLLECT on the first cycle the counter equals STABLE_CYCLES with legal an, capture digit i once: store its nibble, set capture-mask bit i, and ignore further captures of digit i until the mask clears.
REQ-015 SHALL encode seg, active-low, to a nibble as follows: 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9, 0001000=A, 1100000=B, 0110001=C, 1000010=D, 0110000=E, 0111000=F.
REQ-016 SHALL, for any other seg pattern, store nibble 0 and set that digit's digit_err bit.
REQ-017 SHALL accept digit captures in any order.
REQ-018 SHALL, on the cycle the fourth mask bit is set, transition to PRESENT, with value, digit_err and valid=1 registered so they are visible the next cycle (1-cycle latency after the final capture).
REQ-019 SHALL, in PRESENT, hold value, digit_err and valid stable and ignore seg and an captures; the stability counter keeps running.
REQ-020 SHALL, in PRESENT on valid&&ready, deassert valid the next cycle, clear the mask and timeout counter, and return to COLLECT.
REQ-021 SHALL, for ready asserted while valid=0, have no effect.
REQ-022 SHALL, in COLLECT with a nonzero mask, increment a timeout counter each cycle; on reaching TIMEOUT it clears the mask and counter without asserting valid.
REQ-023 SHALL clear the timeout counter while the mask is zero.
REQ-024 SHALL, when a digit capture and a timeout occur in the same cycle, give timeout precedence so the capture is dropped.

Reset
REQ-025 SHALL, while rst_n=0, immediately force state=COLLECT, valid=0, value=16'h0000, digit_err=4'b0000, mask=0, stability counter=0 and timeout counter=0.
REQ-026 SHALL, on reset asserted mid-frame or in PRESENT, discard the frame; after release, collection restarts from an empty mask.

Configuration
REQ-027 SHALL, with macro SEG7_SCAN_READER_ERRCNT_EN defined, add output err_cnt, 8 bits, reset 0, incremented by 1 on each cycle a frame is presented with any digit_err bit set and saturating at 255.
REQ-028 SHALL, with SEG7_SCAN_READER_ERRCNT_EN undefined, have no err_cnt port or counter logic, with all other behaviour identical.

Verification
REQ-029 SHALL verify in-order capture: scan digits 0..3 with patterns for 1,2,3,4, each held 6 cycles, and ready=1 -> value=16'h4321, digit_err=0, valid for 1 cycle.
REQ-030 SHALL verify glitch rejection: digit 2 shows 0000000 for 3 cycles then 0001000 for 4 cycles -> digit 2 captures A, not 8.
REQ-031 SHALL verify invalid-pattern flagging and handshake hold: digit 1 = 1111110 -> digit_err=4'b0010 and nibble 1 = 0; with ready=0 for 20 cycles, valid and value stay held throughout.
REQ-032 SHALL verify timeout: capture digits 0 and 1 only, then hold an=4'b1111 with TIMEOUT=100 -> no valid, mask cleared at cycle 100, and a subsequent full scan yields the correct new value.
REQ-033 SHALL verify illegal an and reset: an=4'b0011 for 10 cycles -> no capture; rst_n pulsed low mid-frame -> valid=0 and value=0 immediately.
REQ-034 SHALL verify the counter with SEG7_SCAN_READER_ERRCNT_EN defined: 300 frames each containing one invalid digit -> err_cnt saturates at 255.
